// File: rtl/rf_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
package rf_pkg;

  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
  localparam int RF_NRP  = 2;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

endpackage : rf_pkg

// File: rtl/rf_read_port.sv
// One read port: hardwired-zero x0, same-cycle write bypass (wr1 over wr0)
// and the pending-write flag as seen by a reader this cycle.
module rf_read_port #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] stored_data,
  input  logic            stored_busy,
  input  logic            run,
  input  logic            wr0_we,
  input  logic [AW-1:0]   wr0_addr,
  input  logic [XLEN-1:0] wr0_data,
  input  logic            wr1_we,
  input  logic [AW-1:0]   wr1_addr,
  input  logic [XLEN-1:0] wr1_data,
  input  logic            iss_we,
  input  logic [AW-1:0]   iss_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_busy
);

  logic addr_zero_s;
  logic hit0_s;
  logic hit1_s;
  logic iss_hit_s;

  // Address match terms; the *_we inputs are already qualified nonzero and in RUN
  always_comb begin
    addr_zero_s = (rd_addr == {AW{1'b0}});
    hit0_s      = wr0_we & (wr0_addr == rd_addr);
    hit1_s      = wr1_we & (wr1_addr == rd_addr);
    iss_hit_s   = iss_we & (iss_addr == rd_addr);
  end

  // Data/busy mux; a write landing this cycle hides the busy bit unless re-issued
  always_comb begin
    rd_data = {XLEN{1'b0}};
    rd_busy = 1'b0;
    if (!run || addr_zero_s) begin
      rd_data = {XLEN{1'b0}};
      rd_busy = 1'b0;
    end else begin
      if (hit1_s) begin
        rd_data = wr1_data;
      end else if (hit0_s) begin
        rd_data = wr0_data;
      end else begin
        rd_data = stored_data;
      end
      rd_busy = stored_busy & ~((hit0_s | hit1_s) & ~iss_hit_s);
    end
  end

endmodule : rf_read_port

// File: rtl/regfile_sb.sv
// Register file with per-register pending-write scoreboard, two writeback
// ports, bypassed reads and a post-reset zeroing sweep.
module regfile_sb
  import rf_pkg::*;
#(
  parameter  int XLEN = RF_XLEN,
  parameter  int NREG = RF_NREG,
  parameter  int NRP  = RF_NRP,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRP-1:0][AW-1:0]    rd_addr,
  output logic [NRP-1:0][XLEN-1:0]  rd_data,
  output logic [NRP-1:0]            rd_busy,
  input  logic                      wr0_en,
  input  logic [AW-1:0]             wr0_addr,
  input  logic [XLEN-1:0]           wr0_data,
  input  logic                      wr1_en,
  input  logic [AW-1:0]             wr1_addr,
  input  logic [XLEN-1:0]           wr1_data,
  input  logic                      iss_en,
  input  logic [AW-1:0]             iss_addr,
  input  logic                      flush,
  output logic                      ready
);

  localparam logic [AW-1:0] IDX_LAST  = AW'(NREG - 1);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

  rf_state_e        state_r;
  rf_state_e        state_nxt_s;
  logic [AW-1:0]    idx_r;
  logic [XLEN-1:0]  mem_r [NREG];
  logic [NREG-1:0]  busy_r;
  logic [NREG-1:0]  busy_nxt_s;
  logic [NREG-1:0]  busy_set_s;
  logic [NREG-1:0]  busy_clr_s;
  logic             run_s;
  logic             init_s;
  logic             wr0_we_s;
  logic             wr1_we_s;
  logic             iss_we_s;
  logic             ready_r;

  function automatic logic [NREG-1:0] addr_decode(input logic en, input logic [AW-1:0] addr);
    logic [NREG-1:0] vec;
    vec       = {NREG{1'b0}};
    vec[addr] = en;
    return vec;
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: leave INIT once the last entry is being zeroed
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (idx_r == IDX_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // FSM output decode
  always_comb begin
    init_s = 1'b0;
    run_s  = 1'b0;
    case (state_r)
      ST_INIT: init_s = 1'b1;
      ST_RUN:  run_s  = 1'b1;
      default: begin
        init_s = 1'b0;
        run_s  = 1'b0;
      end
    endcase
  end

  // Qualified write/issue strobes: RUN only, x0 discarded, flush cancels issue
  always_comb begin
    wr0_we_s = run_s & wr0_en & (wr0_addr != ADDR_ZERO);
    wr1_we_s = run_s & wr1_en & (wr1_addr != ADDR_ZERO);
    iss_we_s = run_s & iss_en & ~flush & (iss_addr != ADDR_ZERO);
  end

  // Sweep counter for the INIT zeroing pass
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r <= {AW{1'b0}};
    end else if (init_s) begin
      idx_r <= idx_r + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      idx_r <= idx_r;
    end
  end

  // Ready flag, registered so it rises together with the RUN state
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s == ST_RUN);
    end
  end

  assign ready = ready_r;

  // Data array: sweep writes in INIT, wr1 written last so it wins a collision
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (init_s) begin
        mem_r[idx_r] <= {XLEN{1'b0}};
      end else begin
        if (wr0_we_s) begin
          mem_r[wr0_addr] <= wr0_data;
        end
        if (wr1_we_s) begin
          mem_r[wr1_addr] <= wr1_data;
        end
      end
    end
  end

  // Busy next value: flush clears everything, otherwise issue beats writeback
  always_comb begin
    busy_clr_s = addr_decode(wr0_we_s, wr0_addr) | addr_decode(wr1_we_s, wr1_addr);
    busy_set_s = addr_decode(iss_we_s, iss_addr);
    busy_nxt_s = busy_r;
    if (!run_s) begin
      busy_nxt_s = busy_r;
    end else if (flush) begin
      busy_nxt_s = {NREG{1'b0}};
    end else begin
      busy_nxt_s = (busy_r & ~busy_clr_s) | busy_set_s;
    end
  end

  // Busy vector register
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    rf_read_port #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_rd (
      .rd_addr     (rd_addr[p]),
      .stored_data (mem_r[rd_addr[p]]),
      .stored_busy (busy_r[rd_addr[p]]),
      .run         (run_s),
      .wr0_we      (wr0_we_s),
      .wr0_addr    (wr0_addr),
      .wr0_data    (wr0_data),
      .wr1_we      (wr1_we_s),
      .wr1_addr    (wr1_addr),
      .wr1_data    (wr1_data),
      .iss_we      (iss_we_s),
      .iss_addr    (iss_addr),
      .rd_data     (rd_data[p]),
      .rd_busy     (rd_busy[p])
    );
  end

endmodule : regfile_sb

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=4); AW=$clog2(NREG).
REQ-003 SHALL have parameter NRP, default 2, number of read ports (>=1).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rd_addr  input  NRP x AW  read addresses.
REQ-007 SHALL have port rd_data  output  NRP x XLEN  read data, combinational.
REQ-008 SHALL have port rd_busy  output  NRP  pending-write (scoreboard) flag per read port.
REQ-009 SHALL have ports wr0_en / wr0_addr / wr0_data  input  1 / AW / XLEN  writeback port 0 (ALU).
REQ-010 SHALL have ports wr1_en / wr1_addr / wr1_data  input  1 / AW / XLEN  writeback port 1 (load).
REQ-011 SHALL have ports iss_en / iss_addr  input  1 / AW  issue: mark destination busy.
REQ-012 SHALL have port flush  input  1  clear all busy bits.
REQ-013 SHALL have port ready  output  1  initialisation complete; block usable.

Function
REQ-014 SHALL implement FSM {INIT, RUN}; INIT zeroes one entry per cycle via counter idx 0..NREG-1, then moves to RUN.
REQ-015 SHALL take exactly NREG cycles in INIT after reset deasserts; ready=1 only in RUN.
REQ-016 SHALL, in INIT, ignore wr0/wr1/iss/flush; rd_data=0, rd_busy=0.
REQ-017 SHALL, in RUN, write wrN_data to wrN_addr at the rising edge when wrN_en=1 and wrN_addr!=0.
REQ-018 SHALL give wr1 priority when wr0 and wr1 target the same nonzero address in one cycle.
REQ-019 SHALL hardwire address 0: rd_data=0, rd_busy=0, writes and issues to 0 discarded.
REQ-020 SHALL bypass same-cycle writes: rd_addr matching an enabled nonzero write address returns that wdata (wr1 over wr0), zero added latency.
REQ-021 SHALL set busy[iss_addr] at the edge when iss_en=1 (RUN, addr!=0).
REQ-022 SHALL clear busy[wrN_addr] at the edge when wrN_en=1.
REQ-023 SHALL keep busy set when an issue and a write target the same address in one cycle (issue wins).
REQ-024 SHALL report rd_busy=0 for an address being written this cycle unless also issued this cycle.
REQ-025 SHALL clear all busy bits at the edge when flush=1; flush overrides same-cycle iss_en; data writes still occur.
REQ-026 SHALL NOT gate writes by busy state; writes to non-busy registers are legal.

Reset
REQ-027 SHALL on reset=1 at an edge: state<=INIT, idx<=0, all busy<=0, ready<=0.
REQ-028 SHALL restart the full INIT sweep if reset asserts mid-INIT or in RUN.
REQ-029 SHALL guarantee every register reads 0 on the first ready=1 cycle.

Structure
REQ-030 SHALL take FSM state enum and default parameter constants from shared package rf_pkg.
REQ-031 SHALL place the bypass/priority read mux in sub-module rf_read_port, instantiated NRP times.
REQ-032 SHALL store data in a single NREG x XLEN array with separate NREG-bit busy vector.

Verification
REQ-033 SHALL cover: reset 1 cycle, release -> ready=0 for 32 cycles, ready=1 on cycle 32, all reads 0.
REQ-034 SHALL cover: wr0 x5=0xDEADBEEF, rd_addr[0]=5 same cycle -> rd_data=0xDEADBEEF; next cycle still 0xDEADBEEF.
REQ-035 SHALL cover: wr0 x7=0x11 and wr1 x7=0x22 same cycle -> bypass and stored value 0x22.
REQ-036 SHALL cover: iss x9, next cycle rd_busy(9)=1; iss x9 + wr1 x9 same cycle -> busy stays 1; wr0 x9 alone -> busy 0.
REQ-037 SHALL cover: write x0=0xFFFF, iss x0 -> rd_data(0)=0, rd_busy(0)=0.
REQ-038 SHALL cover: busy x3,x4 then flush with iss x6 -> all busy 0; reset at INIT cycle 10 -> ready at 32 cycles after release.
